pipe_hazard_ctrl: RTL

- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Generalises the existing two-operand EX forwarding to NUM_SRC operands of configurable width and register-address width.
- Adds load-use stall, taken-branch flush, and a multi-cycle data-memory wait FSM.
- Adds saturating stall/flush performance counters; sits beside the stage registers and drives their stall/flush inputs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/pipe_hazard_ctrl_fwd_mux_unit.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
// Contents:
//   FWD_RF/FWD_WB/FWD_MEM  2-bit operand source encodings.
//   mem_state_e            data-memory wait FSM states.
//   sat_inc                saturating increment for counters up to 64 bits wide.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Returns val+1 unless val already holds the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller.
// master: the pipeline (drives stage fields, receives stall/flush/forwarding).
// slave : pipe_hazard_ctrl (receives stage fields, drives stall/flush/forwarding).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 3,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
);

    logic [NUM_SRC*RADDR_W-1:0] id_rs;
    logic [NUM_SRC-1:0]         id_rs_used;
    logic [RADDR_W-1:0]         id_ex_rd;
    logic                       id_ex_is_load;
    logic [NUM_SRC*RADDR_W-1:0] ex_rs;
    logic [NUM_SRC*DATA_W-1:0]  ex_rs_data;
    logic [RADDR_W-1:0]         ex_mem_rd;
    logic                       ex_mem_reg_wr;
    logic                       ex_mem_is_load;
    logic [DATA_W-1:0]          ex_mem_alu_data;
    logic [RADDR_W-1:0]         mem_wb_rd;
    logic                       mem_wb_reg_wr;
    logic [DATA_W-1:0]          mem_wb_data;
    logic                       mem_req;
    logic                       branch_taken;

    logic [NUM_SRC*2-1:0]       fwd_sel;
    logic [NUM_SRC*DATA_W-1:0]  fwd_data;
    logic                       pc_stall;
    logic                       if_id_stall;
    logic                       if_id_flush;
    logic                       id_ex_stall;
    logic                       id_ex_flush;
    logic                       ex_mem_stall;
    logic                       mem_wb_flush;
    logic [CNT_W-1:0]           stall_cnt;
    logic [CNT_W-1:0]           flush_cnt;

    modport master (
        output id_rs, id_rs_used, id_ex_rd, id_ex_is_load, ex_rs, ex_rs_data,
               ex_mem_rd, ex_mem_reg_wr, ex_mem_is_load, ex_mem_alu_data,
               mem_wb_rd, mem_wb_reg_wr, mem_wb_data, mem_req, branch_taken,
        input  fwd_sel, fwd_data, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
               id_ex_flush, ex_mem_stall, mem_wb_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rs_used, id_ex_rd, id_ex_is_load, ex_rs, ex_rs_data,
               ex_mem_rd, ex_mem_reg_wr, ex_mem_is_load, ex_mem_alu_data,
               mem_wb_rd, mem_wb_reg_wr, mem_wb_data, mem_req, branch_taken,
        output fwd_sel, fwd_data, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
               id_ex_flush, ex_mem_stall, mem_wb_flush, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_mux_unit.sv
// Single-operand forwarding compare-and-select.
// Ports:
//   i_rs, i_rf_data                       operand register address and regfile value
//   i_mem_rd/_reg_wr/_is_load, i_mem_data EX/MEM stage producer
//   i_wb_rd/_reg_wr, i_wb_data            MEM/WB stage producer
//   o_sel, o_data                         chosen source encoding and operand value
module fwd_mux_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RADDR_W  = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic [RADDR_W-1:0] i_rs,
    input  logic [DATA_W-1:0]  i_rf_data,
    input  logic [RADDR_W-1:0] i_mem_rd,
    input  logic               i_mem_reg_wr,
    input  logic               i_mem_is_load,
    input  logic [DATA_W-1:0]  i_mem_data,
    input  logic [RADDR_W-1:0] i_wb_rd,
    input  logic               i_wb_reg_wr,
    input  logic [DATA_W-1:0]  i_wb_data,
    output logic [1:0]         o_sel,
    output logic [DATA_W-1:0]  o_data
);

    always_comb begin
        o_sel  = FWD_RF;
        o_data = i_rf_data;
        if (!(ZERO_REG && (i_rs == '0))) begin
            // A load's EX/MEM value is only an address; its data arrives via MEM/WB.
            if (i_mem_reg_wr && !i_mem_is_load && (i_mem_rd == i_rs)) begin
                o_sel  = FWD_MEM;
                o_data = i_mem_data;
            end else if (i_wb_reg_wr && (i_wb_rd == i_rs)) begin
                o_sel  = FWD_WB;
                o_data = i_wb_data;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; forces all stall/flush outputs low at once
//   bus    pipe_hazard_ctrl_if.slave: stage fields in, forwarding/stall/flush/counters out
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RADDR_W  = 3,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned CNT_W    = 16,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned CntW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    mem_state_e          r_state;
    logic [CntW-1:0]     r_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic [NUM_SRC*2-1:0]      w_fwd_sel;
    logic [NUM_SRC*DATA_W-1:0] w_fwd_data;
    logic                      w_load_use;
    logic                      w_mem_stall;
    logic                      w_pc_stall;
    logic                      w_if_id_stall;
    logic                      w_if_id_flush;
    logic                      w_id_ex_stall;
    logic                      w_id_ex_flush;
    logic                      w_ex_mem_stall;
    logic                      w_mem_wb_flush;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        fwd_mux_unit #(
            .DATA_W   (DATA_W),
            .RADDR_W  (RADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_fwd (
            .i_rs          (bus.ex_rs[g*RADDR_W +: RADDR_W]),
            .i_rf_data     (bus.ex_rs_data[g*DATA_W +: DATA_W]),
            .i_mem_rd      (bus.ex_mem_rd),
            .i_mem_reg_wr  (bus.ex_mem_reg_wr),
            .i_mem_is_load (bus.ex_mem_is_load),
            .i_mem_data    (bus.ex_mem_alu_data),
            .i_wb_rd       (bus.mem_wb_rd),
            .i_wb_reg_wr   (bus.mem_wb_reg_wr),
            .i_wb_data     (bus.mem_wb_data),
            .o_sel         (w_fwd_sel[g*2 +: 2]),
            .o_data        (w_fwd_data[g*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.id_ex_is_load && bus.id_rs_used[i] &&
                (bus.id_rs[i*RADDR_W +: RADDR_W] == bus.id_ex_rd) &&
                !(ZERO_REG && (bus.id_ex_rd == '0))) begin
                w_load_use = 1'b1;
            end
        end
    end

    // DONE is the final cycle of an access: no stall there, so mem_req is ignored.
    assign w_mem_stall = ((r_state == RUN) && bus.mem_req && (MEM_LAT > 1)) ||
                         (r_state == WAIT);

    always_comb begin
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_mem_wb_flush = 1'b0;
        if (rst_n) begin
            if (w_mem_stall) begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_stall  = 1'b1;
                w_ex_mem_stall = 1'b1;
                w_mem_wb_flush = 1'b1;
            end else if (bus.branch_taken) begin
                // Any load-use consumer sits in IF/ID and is squashed here.
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (bus.mem_req && (MEM_LAT > 1)) begin
                        if (MEM_LAT == 2) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CntW'(MEM_LAT - 3);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) r_state <= DONE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                DONE:    r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (w_pc_stall)    r_stall_cnt <= CNT_W'(sat_inc(64'(r_stall_cnt), CNT_W));
            if (w_if_id_flush) r_flush_cnt <= CNT_W'(sat_inc(64'(r_flush_cnt), CNT_W));
        end
    end

    assign bus.fwd_sel      = w_fwd_sel;
    assign bus.fwd_data     = w_fwd_data;
    assign bus.pc_stall     = w_pc_stall;
    assign bus.if_id_stall  = w_if_id_stall;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_stall  = w_id_ex_stall;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.ex_mem_stall = w_ex_mem_stall;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule
